// File: rtl/bbpd_pkg.sv
// bbpd_pkg -- shared types and helpers for the bang-bang phase detector voter.
//
// Contents:
//   dec_t   : phase decision encoding (DEC_NONE / DEC_EARLY / DEC_LATE)
//   decide  : maps a signed net vote onto a decision given a threshold
package bbpd_pkg;

    typedef enum logic [1:0] {
        DEC_NONE  = 2'b00,
        DEC_EARLY = 2'b01,
        DEC_LATE  = 2'b10
    } dec_t;

    // A net of zero can never reach a threshold of at least 1, so equal
    // early and late counts always resolve to DEC_NONE.
    function automatic dec_t decide(input int net, input int thresh);
        if (net >= thresh) begin
            return DEC_EARLY;
        end else if (net <= -thresh) begin
            return DEC_LATE;
        end else begin
            return DEC_NONE;
        end
    endfunction

endpackage

// File: rtl/bbpd_cell.sv
// bbpd_cell -- single-bit Alexander (bang-bang) phase classifier.
//
// Ports:
//   d_prev  in  1  data sample preceding the edge sample
//   e       in  1  edge sample between d_prev and d
//   d       in  1  current data sample
//   prev_ok in  1  d_prev is meaningful; when low the bit is never classified
//   early   out 1  transition seen and edge sample matches the old value
//   late    out 1  transition seen and edge sample matches the new value
module bbpd_cell
    import bbpd_pkg::*;
(
    input  logic d_prev,
    input  logic e,
    input  logic d,
    input  logic prev_ok,
    output logic early,
    output logic late
);

    logic trans;

    assign trans = prev_ok & (d_prev ^ d);
    assign early = trans & (e == d_prev);
    assign late  = trans & (e == d);

endmodule

// File: rtl/bbpd_vote.sv
// bbpd_vote -- windowed majority voter for a bang-bang phase detector.
//
// Each accepted word is classified bit-by-bit into early/late transitions,
// the per-word counts are registered (stage 1), then accumulated over WINDOW
// words (stage 2). At window completion the signed net vote and its
// thresholded decision are published together with a one-cycle valid pulse.
//
// Parameters: WIDTH (bits per word), WINDOW (words per vote), THRESH
// (minimum |net| for a decision).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   en         in   1      data/edge_s valid this cycle
//   data       in   WIDTH  data samples, bit 0 earliest
//   edge_s     in   WIDTH  edge samples, edge_s[i] between data[i-1] and data[i]
//   vote_valid out  1      pulse at window completion
//   vote_dec   out  2      window decision (01 early, 10 late, 00 none)
//   net_vote   out  NW     signed early-minus-late sum of the last window
//   word_valid out  1      (BBPD_WORD_DEC_EN only) per-word decision valid
//   word_dec   out  2      (BBPD_WORD_DEC_EN only) per-word decision, threshold 1
//
// Optional feature macro: BBPD_WORD_DEC_EN adds the per-word decision outputs.
module bbpd_vote
    import bbpd_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int WINDOW = 4,
    parameter  int THRESH = 2,
    localparam int NW     = $clog2(WIDTH * WINDOW + 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] edge_s,
    output logic             vote_valid,
    output logic [1:0]       vote_dec,
`ifdef BBPD_WORD_DEC_EN
    output logic             word_valid,
    output logic [1:0]       word_dec,
`endif
    output logic [NW-1:0]    net_vote
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic             prev_bit_q,   prev_bit_d;
    logic             prev_valid_q, prev_valid_d;
    logic [CW-1:0]    early_q,      early_d;
    logic [CW-1:0]    late_q,       late_d;
    logic             s1_valid_q,   s1_valid_d;
    logic [NW-1:0]    acc_q,        acc_d;
    logic [KW-1:0]    cnt_q,        cnt_d;
    logic [NW-1:0]    net_q,        net_d;
    dec_t             dec_q,        dec_d;
    logic             vote_valid_q, vote_valid_d;

    logic [WIDTH-1:0] d_prev_vec;
    logic [WIDTH-1:0] ok_vec;
    logic [WIDTH-1:0] cell_early;
    logic [WIDTH-1:0] cell_late;
    logic [CW-1:0]    early_cnt;
    logic [CW-1:0]    late_cnt;
    logic [NW-1:0]    sum;

    // Bit 0 looks back to the last bit of the previous accepted word; that
    // lookback is only trusted once a word has been accepted since reset.
    assign d_prev_vec = {data[WIDTH-2:0], prev_bit_q};
    assign ok_vec     = {{(WIDTH-1){1'b1}}, prev_valid_q};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        bbpd_cell u_cell (
            .d_prev  (d_prev_vec[i]),
            .e       (edge_s[i]),
            .d       (data[i]),
            .prev_ok (ok_vec[i]),
            .early   (cell_early[i]),
            .late    (cell_late[i])
        );
    end

    always_comb begin
        early_cnt = '0;
        late_cnt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            early_cnt = early_cnt + CW'(cell_early[i]);
            late_cnt  = late_cnt  + CW'(cell_late[i]);
        end
    end

    // Stage 1: lookback bit and per-word counts.
    always_comb begin
        prev_bit_d   = prev_bit_q;
        prev_valid_d = prev_valid_q;
        early_d      = early_q;
        late_d       = late_q;
        s1_valid_d   = en;
        if (en) begin
            prev_bit_d   = data[WIDTH-1];
            prev_valid_d = 1'b1;
            early_d      = early_cnt;
            late_d       = late_cnt;
        end
    end

    // Stage 2: accumulate; NW bits hold +/-WIDTH*WINDOW so no clamp is needed.
    assign sum = acc_q + NW'(early_q) - NW'(late_q);

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        net_d        = net_q;
        dec_d        = dec_q;
        vote_valid_d = 1'b0;
        if (s1_valid_q) begin
            if (cnt_q == KW'(WINDOW - 1)) begin
                net_d        = sum;
                dec_d        = decide(int'($signed(sum)), THRESH);
                vote_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_bit_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            early_q      <= '0;
            late_q       <= '0;
            s1_valid_q   <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            net_q        <= '0;
            dec_q        <= DEC_NONE;
            vote_valid_q <= 1'b0;
        end else begin
            prev_bit_q   <= prev_bit_d;
            prev_valid_q <= prev_valid_d;
            early_q      <= early_d;
            late_q       <= late_d;
            s1_valid_q   <= s1_valid_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            net_q        <= net_d;
            dec_q        <= dec_d;
            vote_valid_q <= vote_valid_d;
        end
    end

    assign vote_valid = vote_valid_q;
    assign vote_dec   = dec_q;
    assign net_vote   = net_q;

`ifdef BBPD_WORD_DEC_EN
    logic word_valid_q, word_valid_d;
    dec_t word_dec_q,   word_dec_d;

    always_comb begin
        word_valid_d = en;
        word_dec_d   = word_dec_q;
        if (en) begin
            word_dec_d = decide(int'(early_cnt) - int'(late_cnt), 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid_q <= 1'b0;
            word_dec_q   <= DEC_NONE;
        end else begin
            word_valid_q <= word_valid_d;
            word_dec_q   <= word_dec_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_dec   = word_dec_q;
`endif

endmodule

// File: tb/tb_bbpd_vote.sv
// tb_bbpd_vote -- self-checking bench for bbpd_vote (WIDTH=8, WINDOW=4, THRESH=2).
// Word vectors come from a table; the expected window result is pushed to a
// scoreboard queue when the last word of a window is driven and popped when
// vote_valid is seen, checking value, decision and two-cycle latency.
module tb_bbpd_vote;
    import bbpd_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] edge_s = 8'h00;
    logic       vote_valid;
    logic [1:0] vote_dec;
    logic [6:0] net_vote;

    bbpd_vote #(.WIDTH(8), .WINDOW(4), .THRESH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .edge_s     (edge_s),
        .vote_valid (vote_valid),
        .vote_dec   (vote_dec),
        .net_vote   (net_vote)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         net;
        logic [1:0] dec;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         rst_before;
        logic [7:0] data;
        logic [7:0] edge_s;
        int         gap;
        bit         last;
        int         exp_net;
        logic [1:0] exp_dec;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (vote_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_vote: vote_valid=1 at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                chk("net_vote", int'($signed(net_vote)), e.net);
                chk("vote_dec", int'(vote_dec), int'(e.dec));
                chk("vote_latency", cyc, e.cyc);
            end
        end
    end

    // Adds count identical words; the final one closes a window when has_exp.
    task automatic add_words(input bit r, input logic [7:0] d, input logic [7:0] e,
                             input int g, input int count, input bit has_exp,
                             input int net, input logic [1:0] dc);
        vec_t v;
        for (int k = 0; k < count; k++) begin
            v.rst_before = r && (k == 0);
            v.data       = d;
            v.edge_s     = e;
            v.gap        = g;
            v.last       = has_exp && (k == count - 1);
            v.exp_net    = v.last ? net : 0;
            v.exp_dec    = v.last ? dc : DEC_NONE;
            vt.push_back(v);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_vote_valid", int'(vote_valid), 0);
            chk("rst_vote_dec", int'(vote_dec), 0);
            chk("rst_net_vote", int'(net_vote), 0);
        end
        rst = 1'b0;
    endtask

    task automatic drive_word(input logic [7:0] d, input logic [7:0] e, input bit last,
                              input int net, input logic [1:0] dc);
        exp_t x;
        @(negedge clk);
        en     = 1'b1;
        data   = d;
        edge_s = e;
        if (last) begin
            x.net = net;
            x.dec = dc;
            x.cyc = cyc + 2;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en     = 1'b0;
            data   = 8'($urandom);
            edge_s = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Early: AA with edge = previous bit -> 8'h55 (bit 0 sees prior bit 7 = 1).
        add_words(1, 8'hAA, 8'h55, 0, 4, 1, 31, DEC_EARLY);
        add_words(0, 8'hAA, 8'h55, 0, 4, 1, 32, DEC_EARLY);
        // Late: edge = data.
        add_words(1, 8'hAA, 8'hAA, 0, 4, 1, -31, DEC_LATE);
        add_words(0, 8'hAA, 8'hAA, 0, 4, 1, -32, DEC_LATE);
        // Idle data.
        add_words(1, 8'h00, 8'h00, 0, 4, 1, 0, DEC_NONE);
        // Single early transition at bit 7: +1, below threshold.
        add_words(1, 8'h00, 8'h00, 0, 2, 0, 0, DEC_NONE);
        add_words(0, 8'h80, 8'h00, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'hFF, 8'hFF, 0, 1, 1, 1, DEC_NONE);
        // Two early transitions: exactly +THRESH.
        add_words(1, 8'h00, 8'h00, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'h80, 8'h00, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'hFF, 8'hFF, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'h00, 8'h01, 0, 1, 1, 2, DEC_EARLY);
        // Two late transitions: exactly -THRESH.
        add_words(1, 8'h00, 8'h00, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'h80, 8'h80, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'hFF, 8'hFF, 0, 1, 0, 0, DEC_NONE);
        add_words(0, 8'h00, 8'h00, 0, 1, 1, -2, DEC_LATE);
        // en gaps with garbage inputs: same sum as gapless.
        add_words(1, 8'hAA, 8'h55, 1, 4, 1, 31, DEC_EARLY);
        // Reset mid-window discards the partial window.
        add_words(1, 8'hAA, 8'hAA, 0, 2, 0, 0, DEC_NONE);
        add_words(1, 8'hAA, 8'h55, 0, 4, 1, 31, DEC_EARLY);

        do_reset(3);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst_before && i != 0) do_reset(2);
            drive_word(vt[i].data, vt[i].edge_s, vt[i].last, vt[i].exp_net, vt[i].exp_dec);
            if (vt[i].gap > 0) idle(vt[i].gap);
        end
        idle(6);

        // rst wins over en: the word presented during reset is not accepted.
        idle(2);
        @(negedge clk);
        rst    = 1'b1;
        en     = 1'b1;
        data   = 8'hAA;
        edge_s = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        for (int k = 0; k < 4; k++) drive_word(8'hAA, 8'h55, k == 3, 31, DEC_EARLY);
        idle(3);

        // Outputs hold between pulses.
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("hold_net_vote", int'($signed(net_vote)), 31);
            chk("hold_vote_dec", int'(vote_dec), int'(DEC_EARLY));
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bbpd_vote.md
BBPD_VOTE -- requirements
Module: bbpd_vote

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data/edge bits per word, minimum 2.
REQ-002 SHALL have parameter WINDOW, default 4: accepted words per vote window, minimum 1.
REQ-003 SHALL have parameter THRESH, default 2: minimum |net| for a decision, minimum 1.
REQ-004 SHALL have port clk  in  1  sole clock; all logic updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  in  1  data and edge_s valid this cycle.
REQ-007 SHALL have port data  in  WIDTH  data samples; bit 0 is the earliest in time.
REQ-008 SHALL have port edge_s  in  WIDTH  edge samples; edge_s[i] lies between data[i-1] and data[i]; edge_s[0] lies between the previous word's data[WIDTH-1] and data[0].
REQ-009 SHALL have port vote_valid  out  1  one-cycle pulse at window completion.
REQ-010 SHALL have port vote_dec  out  2  window decision: 2'b01 EARLY, 2'b10 LATE, 2'b00 NONE.
REQ-011 SHALL have port net_vote  out  NW  signed early-minus-late sum for the window; NW = clog2(WIDTH*WINDOW+1)+1.

Function
REQ-012 Per bit i, SHALL classify (Dprev, E, D) = (data[i-1] or the previous word's bit, edge_s[i], data[i]): Dprev!=D and E==Dprev -> EARLY; Dprev!=D and E==D -> LATE; otherwise NONE.
REQ-013 Stage 1 SHALL register the per-word early and late counts, each clog2(WIDTH+1) bits, one cycle after an en=1 word.
REQ-014 Stage 2 SHALL add (early - late) into a signed accumulator and increment a word counter from 0 to WINDOW-1.
REQ-015 The accumulator SHALL be sized exactly (NW bits), so no saturation is needed; overflow is impossible.
REQ-016 On the WINDOW-th accepted word, SHALL load net_vote with the final sum, set vote_dec, pulse vote_valid, and clear the accumulator and counter in the same cycle.
REQ-017 Latency: if the WINDOW-th word is sampled at cycle t, vote_valid SHALL be high at cycle t+2.
REQ-018 vote_dec SHALL be EARLY if net >= THRESH, LATE if net <= -THRESH, else NONE; equal early and late counts give NONE.
REQ-019 en=0 cycles SHALL leave the previous-bit register, counter and accumulator unchanged.
REQ-020 net_vote and vote_dec SHALL hold their values between pulses.
REQ-021 A prev_valid flag SHALL mark the previous-bit register as valid.
REQ-022 On the first accepted word after reset (prev_valid=0), bit 0 SHALL be classified NONE.

Reset
REQ-023 rst=1 SHALL clear the following: vote_valid, vote_dec, net_vote, the accumulator, the word counter, stage 1 counts, prev_valid and the previous-bit register.
REQ-024 Reset mid-window SHALL discard the partial window; the next vote requires WINDOW fresh words.
REQ-025 rst SHALL take priority over en in the same cycle.

Configuration
REQ-026 Macro BBPD_WORD_DEC_EN defined: SHALL add outputs word_valid (1 bit) and word_dec (2 bits).
REQ-027 word_valid and word_dec SHALL be valid one cycle after each accepted word, using the REQ-018 rule with threshold 1 on that word's counts, and SHALL reset to 0.
REQ-028 Macro undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package bbpd_pkg SHALL hold the decision typedef and the constants DEC_NONE, DEC_EARLY and DEC_LATE.
REQ-030 Sub-module bbpd_cell SHALL be the single-bit combinational classifier, instantiated WIDTH times.

Verification (WIDTH=8, WINDOW=4, THRESH=2)
REQ-031 Reset: hold rst for 3 cycles -> all outputs 0; no vote_valid pulse.
REQ-032 Early: data=8'hAA and edge_s[i]=previous bit, 4 words -> net_vote=+31 (7+8+8+8), EARLY, vote_valid at t+2; the next window gives +32.
REQ-033 Late: data=8'hAA and edge_s=data, 4 words -> net_vote=-31, LATE; the next window gives -32.
REQ-034 Idle data and threshold: data=8'h00 for 4 words -> net 0, NONE; a single early transition in a window -> net +1, NONE.
REQ-035 en gaps: en high every other cycle -> vote_valid only after the 4th accepted word, and the sum matches the gapless case.
REQ-036 Reset mid-window: rst after 2 words, then 4 words of 8'hAA early -> net_vote=+31 (bit 0 of the first word skipped).
